radix_4_div_ctrl: RTL

Iteration controller for the radix-4 SRT integer divider datapath (remainder carry-save registers, quotient selection, sign detector on the remainder MSBs). It accepts one operation at a time via valid/ready, computes the iteration count from the operand leading-zero counts, and sequences the pre-process, iteration and post-correction enables. It uses the final remainder sign to request quotient/remainder correction, and hands the result back via valid/ready.

---
 rtl/radix_4_div_pkg.sv | 25 ++
 rtl/radix_4_iter_cnt.sv | 64 ++++++
 rtl/radix_4_div_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/radix_4_div_pkg.sv
// -----------------------------------------------------------------------------
// radix_4_div_pkg
// Shared types and default sizing for the radix-4 SRT divider controller.
//   state_e      : one-hot controller state encoding
//   DIV_WIDTH    : default operand width
//   DIV_LZC_W    : default width of the leading-zero counts
//   DIV_CNT_W    : default width of the iteration counter
//   DIV_MAX_ITER : largest iteration count for the default width
// -----------------------------------------------------------------------------
package radix_4_div_pkg;

  localparam int DIV_WIDTH    = 64;
  localparam int DIV_LZC_W    = $clog2(DIV_WIDTH);
  localparam int DIV_CNT_W    = $clog2(DIV_WIDTH / 2 + 1);
  localparam int DIV_MAX_ITER = DIV_WIDTH / 2;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_PRE  = 5'b00010,
    ST_ITER = 5'b00100,
    ST_POST = 5'b01000,
    ST_DONE = 5'b10000
  } state_e;

endpackage : radix_4_div_pkg

// File: rtl/radix_4_iter_cnt.sv
// -----------------------------------------------------------------------------
// radix_4_iter_cnt
// Loadable down-counter holding the number of radix-4 iterations remaining.
// The load value is one iteration per two bits of leading-zero difference,
// plus one, so a dividend/divisor pair with equal magnitude ranges still
// runs a single iteration.
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr_i            : clear counter to 0 (flush)
//   load_i           : load count derived from the lzc inputs
//   dec_i            : decrement by one (one iteration performed)
//   dividend_lzc_i   : leading zeros of |dividend| (latched copy)
//   divisor_lzc_i    : leading zeros of |divisor| (latched copy)
//   cnt_o            : iterations remaining
//   last_o           : current iteration is the final one (cnt_o == 1)
// -----------------------------------------------------------------------------
module radix_4_iter_cnt
  import radix_4_div_pkg::*;
#(
  parameter int LZC_W = DIV_LZC_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LZC_W-1:0] dividend_lzc_i,
  input  logic [LZC_W-1:0] divisor_lzc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [LZC_W-1:0] lzc_diff;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Only loaded when divisor_lzc >= dividend_lzc, so the difference never wraps.
  // The maximum load, (2^LZC_W-1 >> 1) + 1 == WIDTH/2, fits in CNT_W bits.
  always_comb begin
    lzc_diff = divisor_lzc_i - dividend_lzc_i;
    load_val = CNT_W'(lzc_diff >> 1) + CNT_W'(1);
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule : radix_4_iter_cnt

// File: rtl/radix_4_div_ctrl.sv
// -----------------------------------------------------------------------------
// radix_4_div_ctrl
// Iteration controller for the radix-4 SRT integer divider datapath.
// Accepts one operation via start valid/ready, derives the iteration count
// from the operand leading-zero counts, sequences the pre-process, iteration
// and post-correction enables, and returns the result via finish valid/ready.
// The controller is sign-agnostic; operand signs are handled in the datapath.
//
// Optional feature, macro RADIX_4_DIV_ZERO_FAST_EN:
//   defined   : divisor_zero_i short-circuits PRE -> DONE with div_zero_o=1
//   undefined : divisor_zero_i is ignored and div_zero_o is tied low
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_valid_i    : new operation offered
//   start_ready_o    : controller can accept (IDLE only)
//   flush_i          : abort current operation, highest priority
//   dividend_lzc_i   : leading zeros of |dividend|, sampled on start handshake
//   divisor_lzc_i    : leading zeros of |divisor|, sampled on start handshake
//   dividend_zero_i  : |dividend| == 0, sampled on start handshake
//   divisor_zero_i   : divisor == 0, sampled on start handshake
//   rem_sign_i       : final remainder sign from the sign detector
//   pre_en_o         : normalisation/load enable (PRE)
//   iter_en_o        : one radix-4 iteration this cycle (ITER)
//   post_en_o        : correction/negation enable (POST)
//   corr_o           : apply quotient/remainder correction, valid with post_en_o
//   early_finish_o   : result is quotient 0 / remainder = dividend (DONE)
//   div_zero_o       : divide-by-zero result (DONE)
//   iter_cnt_o       : iterations remaining
//   finish_valid_o   : result valid (DONE)
//   finish_ready_i   : consumer accepts result
// -----------------------------------------------------------------------------
module radix_4_div_ctrl
  import radix_4_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int LZC_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH / 2 + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic             flush_i,
  input  logic [LZC_W-1:0] dividend_lzc_i,
  input  logic [LZC_W-1:0] divisor_lzc_i,
  input  logic             dividend_zero_i,
  input  logic             divisor_zero_i,
  input  logic             rem_sign_i,
  output logic             pre_en_o,
  output logic             iter_en_o,
  output logic             post_en_o,
  output logic             corr_o,
  output logic             early_finish_o,
  output logic             div_zero_o,
  output logic [CNT_W-1:0] iter_cnt_o,
  output logic             finish_valid_o,
  input  logic             finish_ready_i
);

  state_e           state_d,    state_q;
  logic [LZC_W-1:0] dvd_lzc_d,  dvd_lzc_q;
  logic [LZC_W-1:0] dvs_lzc_d,  dvs_lzc_q;
  logic             dvd_zero_d, dvd_zero_q;
  logic             early_d,    early_q;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
  logic             dvs_zero_d, dvs_zero_q;
  logic             dz_d,       dz_q;
`else
  logic             unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero_i;
`endif

  logic cnt_load;
  logic cnt_dec;
  logic cnt_last;
  logic is_early;

  // Quotient is zero when the dividend is zero or has a smaller magnitude
  // range than the divisor.
  assign is_early = dvd_zero_q || (dvd_lzc_q > dvs_lzc_q);

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    dvd_lzc_d  = dvd_lzc_q;
    dvs_lzc_d  = dvs_lzc_q;
    dvd_zero_d = dvd_zero_q;
    early_d    = early_q;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
    dvs_zero_d = dvs_zero_q;
    dz_d       = dz_q;
`endif
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (flush_i) begin
      // Flush wins over every transition, including a same-cycle start.
      state_d = ST_IDLE;
      early_d = 1'b0;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
      dz_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_valid_i) begin
            dvd_lzc_d  = dividend_lzc_i;
            dvs_lzc_d  = divisor_lzc_i;
            dvd_zero_d = dividend_zero_i;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
            dvs_zero_d = divisor_zero_i;
`endif
            state_d    = ST_PRE;
          end
        end
        ST_PRE: begin
`ifdef RADIX_4_DIV_ZERO_FAST_EN
          if (dvs_zero_q) begin
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else
`endif
          if (is_early) begin
            early_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_ITER;
          end
        end
        ST_ITER: begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = ST_POST;
          end
        end
        ST_POST: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (finish_ready_i) begin
            early_d = 1'b0;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
            dz_d    = 1'b0;
`endif
            state_d = ST_IDLE;
          end
        end
        default: begin
          // Recover from a corrupted one-hot code.
          state_d = ST_IDLE;
          early_d = 1'b0;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
          dz_d    = 1'b0;
`endif
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dvd_lzc_q  <= '0;
      dvs_lzc_q  <= '0;
      dvd_zero_q <= 1'b0;
      early_q    <= 1'b0;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
      dvs_zero_q <= 1'b0;
      dz_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dvd_lzc_q  <= dvd_lzc_d;
      dvs_lzc_q  <= dvs_lzc_d;
      dvd_zero_q <= dvd_zero_d;
      early_q    <= early_d;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
      dvs_zero_q <= dvs_zero_d;
      dz_q       <= dz_d;
`endif
    end
  end

  radix_4_iter_cnt #(
    .LZC_W (LZC_W),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (flush_i),
    .load_i         (cnt_load),
    .dec_i          (cnt_dec),
    .dividend_lzc_i (dvd_lzc_q),
    .divisor_lzc_i  (dvs_lzc_q),
    .cnt_o          (iter_cnt_o),
    .last_o         (cnt_last)
  );

  // Enables decode straight from the state flops, so they are glitch-free and
  // mutually exclusive by construction of the one-hot code.
  assign start_ready_o  = (state_q == ST_IDLE);
  assign pre_en_o       = (state_q == ST_PRE);
  assign iter_en_o      = (state_q == ST_ITER);
  assign post_en_o      = (state_q == ST_POST);
  assign finish_valid_o = (state_q == ST_DONE);
  // The remainder sign is only known in POST, so correction is same-cycle.
  assign corr_o         = post_en_o & rem_sign_i;
  assign early_finish_o = early_q;
`ifdef RADIX_4_DIV_ZERO_FAST_EN
  assign div_zero_o     = dz_q;
`else
  assign div_zero_o     = 1'b0;
`endif

endmodule : radix_4_div_ctrl
